vending_machine_param: RTL and testbench

Parametrised successor to the single-product coin vending FSM. It accepts 5/10/25-unit coins into a bounded credit register and serves one of NUM_PROD products, each with its own price. It returns change as a stream of one coin code per cycle using a greedy largest-coin-first policy, and supports cancel/refund. It sits between the coin acceptor front-end and the dispenser/coin-hopper drivers, all in the single system clock domain.

---
 rtl/vending_machine_param.sv | 189 ++++++++++++++++++
 tb/tb_vending_machine_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Purpose: multi-product coin vending FSM with bounded credit, greedy change return and refund.
// Latency: selection at edge N gives vend pulse in cycle N..N+1; change coins follow back-to-back.
// Backpressure: none; coins are rejected (coin_reject) while busy, on cancel or past MAX_CREDIT.
module vending_machine_param #(
  parameter int NUM_PROD = 4,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd100, 8'd65, 8'd50, 8'd35},
  parameter int MAX_CREDIT = 200
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  in_i,
  input  logic                        cancel_i,
  input  logic                        sel_valid_i,
  input  logic [$clog2(NUM_PROD)-1:0] sel_id_i,
  output logic                        out_o,
  output logic [$clog2(NUM_PROD)-1:0] out_id_o,
  output logic [1:0]                  change_o,
  output logic [CREDIT_W-1:0]         credit_o,
  output logic                        busy_o,
  output logic                        coin_reject_o,
  output logic                        insufficient_o
);

  localparam int ID_W = $clog2(NUM_PROD);

  // Sum of credit and a coin is formed one bit wider so it can never wrap.
  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  // Monetary value of a coin code.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W-1:0] v;
    case (code)
      COIN_5:  v = CREDIT_W'(5);
      COIN_10: v = CREDIT_W'(10);
      COIN_25: v = CREDIT_W'(25);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Greedy largest-coin-first choice for the remaining credit.
  function automatic logic [1:0] change_code(input logic [CREDIT_W-1:0] cr);
    logic [1:0] c;
    if (cr >= CREDIT_W'(25))      c = COIN_25;
    else if (cr >= CREDIT_W'(10)) c = COIN_10;
    else if (cr != '0)            c = COIN_5;
    else                          c = COIN_NONE;
    return c;
  endfunction

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic                out_q;
  logic [1:0]          change_q;
  logic                busy_q;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;

  logic                coin_present;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;
  logic [CREDIT_W-1:0] base;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] chg_val;

  assign coin_present = (in_i != COIN_NONE);
  assign coin_val     = coin_value(in_i);
  assign chg_val      = coin_value(change_code(credit_q));

  // With a power-of-two product count every index is legal; otherwise range-check it.
  if (NUM_PROD == (1 << ID_W)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_range
    assign sel_ok = ({1'b0, sel_id_i} < (ID_W+1)'(NUM_PROD));
  end

  // Price lookup for the selected product; out-of-range indices read as zero and are refused via sel_ok.
  always_comb begin
    sel_price = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel_id_i == ID_W'(i)) sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  // Next-state, next-credit and refusal pulses.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    out_id_d       = out_id_q;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    base           = credit_q;
    sum            = '0;

    case (state_q)
      ST_ACCEPT: begin
        if (cancel_i) begin
          // Refund wins over everything; a coin in the same cycle goes back untouched.
          coin_reject_d = coin_present;
          if (credit_q != '0) state_d = ST_CHANGE;
        end else begin
          if (sel_valid_i) begin
            if (sel_ok && (credit_q >= sel_price)) begin
              base     = credit_q - sel_price;
              out_id_d = sel_id_i;
              state_d  = ST_VEND;
            end else begin
              insufficient_d = 1'b1;
            end
          end
          credit_d = base;
          // The coin limit is judged against credit after any purchase in this edge.
          if (coin_present) begin
            sum = {1'b0, base} + {1'b0, coin_val};
            if (sum <= MAX_SUM) credit_d = sum[CREDIT_W-1:0];
            else                coin_reject_d = 1'b1;
          end
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_present;
        state_d       = (credit_q != '0) ? ST_CHANGE : ST_ACCEPT;
      end

      ST_CHANGE: begin
        coin_reject_d = coin_present;
        // Clamp at zero so a stray non-multiple of 5 can never wrap the register.
        if (credit_q <= chg_val) begin
          credit_d = '0;
          state_d  = ST_ACCEPT;
        end else begin
          credit_d = credit_q - chg_val;
        end
      end

      default: begin
        state_d  = ST_ACCEPT;
        credit_d = '0;
      end
    endcase
  end

  // State and registered outputs; Moore outputs are precomputed from the next state and credit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_ACCEPT;
      credit_q       <= '0;
      out_id_q       <= '0;
      out_q          <= 1'b0;
      change_q       <= COIN_NONE;
      busy_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      out_id_q       <= out_id_d;
      out_q          <= (state_d == ST_VEND);
      change_q       <= (state_d == ST_CHANGE) ? change_code(credit_d) : COIN_NONE;
      busy_q         <= (state_d != ST_ACCEPT);
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
    end
  end

  assign out_o          = out_q;
  assign out_id_o       = out_id_q;
  assign change_o       = change_q;
  assign credit_o       = credit_q;
  assign busy_o         = busy_q;
  assign coin_reject_o  = coin_reject_q;
  assign insufficient_o = insufficient_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param with default parameters
// (prices: id0=35, id1=50, id2=65, id3=100; MAX_CREDIT=200).
module tb_vending_machine_param;

  logic       clk;
  logic       rst;
  logic [1:0] in_c;
  logic       cancel;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       out;
  logic [1:0] out_id;
  logic [1:0] change;
  logic [7:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       insufficient;

  int n_chk = 0;
  int n_err = 0;

  vending_machine_param dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_i           (in_c),
    .cancel_i       (cancel),
    .sel_valid_i    (sel_valid),
    .sel_id_i       (sel_id),
    .out_o          (out),
    .out_id_o       (out_id),
    .change_o       (change),
    .credit_o       (credit),
    .busy_o         (busy),
    .coin_reject_o  (coin_reject),
    .insufficient_o (insufficient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_c = 2'b00; cancel = 1'b0; sel_valid = 1'b0; sel_id = 2'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic coin(input logic [1:0] c);
    in_c = c;
    tick();
    in_c = 2'b00;
  endtask

  task automatic select(input logic [1:0] id, input logic [1:0] c);
    sel_valid = 1'b1; sel_id = id; in_c = c;
    tick();
    idle();
  endtask

  task automatic make_40();
    coin(2'b11); coin(2'b10); coin(2'b01);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_credit", credit, 0);
    chk("rst_out", out, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_change", change, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coin_reject", coin_reject, 0);
    chk("rst_insufficient", insufficient, 0);

    // Cancel with zero credit stays idle
    cancel = 1'b1; tick(); idle();
    chk("cancel0_busy", busy, 0);
    chk("cancel0_change", change, 0);

    // Exact payment: 25 + 10 = 35, product 0
    do_reset();
    coin(2'b11); coin(2'b10);
    chk("exact_credit", credit, 35);
    select(2'd0, 2'b00);
    chk("exact_out", out, 1);
    chk("exact_out_id", out_id, 0);
    chk("exact_change_vend", change, 0);
    chk("exact_credit_vend", credit, 0);
    chk("exact_busy_vend", busy, 1);
    tick();
    chk("exact_out_after", out, 0);
    chk("exact_busy_after", busy, 0);
    chk("exact_change_after", change, 0);

    // Change: 75 credit, product 2 (65) -> one 10 coin
    do_reset();
    coin(2'b11); coin(2'b11); coin(2'b11);
    chk("chg_credit", credit, 75);
    select(2'd2, 2'b00);
    chk("chg_out", out, 1);
    chk("chg_out_id", out_id, 2);
    chk("chg_credit_vend", credit, 10);
    tick();
    chk("chg_out_low", out, 0);
    chk("chg_coin", change, 2'b10);
    chk("chg_out_id_hold", out_id, 2);
    chk("chg_busy", busy, 1);
    tick();
    chk("chg_done_change", change, 0);
    chk("chg_done_credit", credit, 0);
    chk("chg_done_busy", busy, 0);

    // Refund of 40 -> 25, 10, 5
    do_reset();
    make_40();
    chk("ref_credit", credit, 40);
    cancel = 1'b1; tick(); idle();
    chk("ref_c1", change, 2'b11);
    chk("ref_cr1", credit, 40);
    chk("ref_busy", busy, 1);
    tick();
    chk("ref_c2", change, 2'b10);
    chk("ref_cr2", credit, 15);
    tick();
    chk("ref_c3", change, 2'b01);
    chk("ref_cr3", credit, 5);
    tick();
    chk("ref_c4", change, 0);
    chk("ref_cr4", credit, 0);
    chk("ref_busy_end", busy, 0);

    // Insufficient credit: 10 vs product 1 (50)
    do_reset();
    coin(2'b10);
    select(2'd1, 2'b00);
    chk("insuf_pulse", insufficient, 1);
    chk("insuf_credit", credit, 10);
    chk("insuf_out", out, 0);
    chk("insuf_busy", busy, 0);
    tick();
    chk("insuf_pulse_end", insufficient, 0);

    // Credit ceiling: 190 + 25 rejected, 190 + 10 = 200 accepted
    do_reset();
    for (int i = 0; i < 7; i++) coin(2'b11);
    coin(2'b10); coin(2'b01);
    chk("max_credit190", credit, 190);
    coin(2'b11);
    chk("max_reject", coin_reject, 1);
    chk("max_credit_kept", credit, 190);
    coin(2'b10);
    chk("max_accept_reject", coin_reject, 0);
    chk("max_credit200", credit, 200);

    // Coin during CHANGE is rejected and refund total is unchanged
    do_reset();
    make_40();
    cancel = 1'b1; tick(); idle();
    chk("cc_c1", change, 2'b11);
    coin(2'b01);
    chk("cc_reject", coin_reject, 1);
    chk("cc_c2", change, 2'b10);
    chk("cc_cr2", credit, 15);
    tick();
    chk("cc_reject_end", coin_reject, 0);
    chk("cc_c3", change, 2'b01);
    chk("cc_cr3", credit, 5);
    tick();
    chk("cc_c4", change, 0);
    chk("cc_cr4", credit, 0);

    // Selection with a coin in the same cycle: 50 - 50 + 5 -> change 5
    do_reset();
    coin(2'b11); coin(2'b11);
    select(2'd1, 2'b01);
    chk("sim_out", out, 1);
    chk("sim_out_id", out_id, 1);
    chk("sim_credit", credit, 5);
    chk("sim_reject", coin_reject, 0);
    tick();
    chk("sim_change", change, 2'b01);
    tick();
    chk("sim_change_end", change, 0);
    chk("sim_busy_end", busy, 0);

    // Cancel and select together: refund only
    do_reset();
    coin(2'b11); coin(2'b10);
    cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0;
    tick(); idle();
    chk("cs_out", out, 0);
    chk("cs_change1", change, 2'b11);
    chk("cs_credit1", credit, 35);
    tick();
    chk("cs_out2", out, 0);
    chk("cs_change2", change, 2'b10);
    tick();
    chk("cs_credit_end", credit, 0);
    chk("cs_busy_end", busy, 0);

    // Reset during second CHANGE cycle of a 40 refund
    do_reset();
    make_40();
    cancel = 1'b1; tick(); idle();
    tick();
    chk("mr_second_change", change, 2'b10);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_change", change, 0);
    chk("mr_credit", credit, 0);
    chk("mr_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_more_change", change, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
